// File: rtl/cmp_pkg.sv
// cmp_pkg: shared op codes, FSM states and compare function for cmp_arbiter
package cmp_pkg;
  localparam logic [2:0] CMP_LT = 3'b000;
  localparam logic [2:0] CMP_LE = 3'b001;
  localparam logic [2:0] CMP_GT = 3'b011;
  localparam logic [2:0] CMP_GE = 3'b100;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  function automatic logic cmp_eval(input logic [2:0] op, input logic lt, input logic eq);
    return op == CMP_LE ? (lt | eq) :
           op == CMP_GT ? !(lt | eq) :
           op == CMP_GE ? !lt : lt;
  endfunction
endpackage

// File: rtl/cmp_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);
  logic [IW-1:0] lo_idx;
  logic [IW-1:0] hi_idx;
  logic          hi_any;
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) lo_idx = IW'(i);
      if (req[i] && i >= int'(ptr)) begin
        hi_idx = IW'(i);
        hi_any = 1'b1;
      end
    end
    gnt_idx = hi_any ? hi_idx : lo_idx;
    gnt     = (|req) ? NUM_REQ'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin sharing of one unsigned compare datapath with tagged responses
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]      req_op,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_result,
  output logic                      busy
);
  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [2:0]          op_q, op_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gidx;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(ID_W)) u_rr (
    .req(req_valid), .ptr(ptr_q), .gnt(gnt), .gnt_idx(gidx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      rid_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      rid_q   <= rid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    rid_d     = rid_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    op_d      = op_q;
    req_ready = '0;
    case (state_q)
      IDLE: if (|req_valid && !rst) begin
        req_ready = gnt;
        a_d       = req_a[gidx*DATA_W +: DATA_W];
        b_d       = req_b[gidx*DATA_W +: DATA_W];
        op_d      = req_op[gidx*3 +: 3];
        gid_d     = gidx;
        state_d   = EXEC;
      end
      EXEC: begin
        res_d   = DATA_W'(cmp_eval(op_q, a_q < b_q, a_q == b_q));
        rid_d   = gid_q;
        state_d = RESP;
      end
      RESP: if (resp_ready) begin
        // pointer moves only on completion so a waiting requester is never starved
        ptr_d   = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_valid  = state_q == RESP;
  assign resp_id     = rid_q;
  assign resp_result = res_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed self-checking bench for cmp_arbiter
module tb_cmp_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [11:0]  req_op;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_result;
  logic         busy;
  int total = 0;
  int bad = 0;

  cmp_arbiter #(.NUM_REQ(4), .DATA_W(32), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_op[idx*3 +: 3]  = op;
  endtask

  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       output logic [3:0] rdy, output logic rv, output logic [1:0] id, output logic [31:0] res);
    @(negedge clk);
    set_req(idx, a, b, op);
    req_valid = 4'b0001 << idx;
    #1 rdy = req_ready;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rv = resp_valid;
    id = resp_id;
    res = resp_result;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL reset_resp_id got=%0d exp=0", resp_id); end
    total++; if (resp_result !== 32'd0) begin bad++; $display("FAIL reset_resp_result got=%h exp=0", resp_result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single;
    do_reset;
    @(negedge clk);
    set_req(0, 32'd5, 32'd9, 3'b000);
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    @(negedge clk);
    req_valid = '0;
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL single_exec_ready got=%b exp=0000", req_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_exec_busy got=%b exp=1", busy); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_exec_valid got=%b exp=0", resp_valid); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL single_resp_valid got=%b exp=1", resp_valid); end
    total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL single_resp_id got=%0d exp=0", resp_id); end
    total++; if (resp_result !== 32'd1) begin bad++; $display("FAIL single_resp_result got=%h exp=1", resp_result); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_done got=%b%b exp=00", resp_valid, busy); end
  endtask

  task automatic test_ops;
    logic [2:0]  ops [5] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b111};
    logic [31:0] exp [5] = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
    logic [3:0]  rdy;
    logic        rv;
    logic [1:0]  id;
    logic [31:0] res;
    do_reset;
    for (int k = 0; k < 5; k++) begin
      do_op(1, 32'd7, 32'd7, ops[k], rdy, rv, id, res);
      total++; if (rdy !== 4'b0010) begin bad++; $display("FAIL op%0d_ready got=%b exp=0010", k, rdy); end
      total++; if (rv !== 1'b1) begin bad++; $display("FAIL op%0d_valid got=%b exp=1", k, rv); end
      total++; if (id !== 2'd1) begin bad++; $display("FAIL op%0d_id got=%0d exp=1", k, id); end
      total++; if (res !== exp[k]) begin bad++; $display("FAIL op%0d_result op=%b got=%h exp=%h", k, ops[k], res, exp[k]); end
    end
  endtask

  task automatic test_round_robin;
    int order [8] = '{0, 1, 2, 3, 0, 2, 3, 2};
    logic [3:0] exp;
    do_reset;
    for (int i = 0; i < 4; i++) set_req(i, 32'(i), 32'd2, 3'b000);
    @(negedge clk);
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c == 15) req_valid = 4'b1100;
      #1;
      exp = (c % 3 == 0) ? 4'b0001 << order[c/3] : 4'b0000;
      total++; if (req_ready !== exp) begin bad++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp); end
      total++; if (resp_valid !== (c % 3 == 2)) begin bad++; $display("FAIL rr_valid c=%0d got=%b exp=%b", c, resp_valid, c % 3 == 2); end
      if (c % 3 == 2) begin
        total++; if (resp_id !== 2'(order[c/3])) begin bad++; $display("FAIL rr_id c=%0d got=%0d exp=%0d", c, resp_id, order[c/3]); end
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    do_reset;
    set_req(0, 32'd0, 32'd0, 3'b000);
    set_req(1, 32'd3, 32'd2, 3'b011);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0011;
    set_req(1, 32'd0, 32'd9, 3'b011);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, resp_valid); end
      total++; if (resp_id !== 2'd1) begin bad++; $display("FAIL bp_id c=%0d got=%0d exp=1", c, resp_id); end
      total++; if (resp_result !== 32'd1) begin bad++; $display("FAIL bp_result c=%0d got=%h exp=1", c, resp_result); end
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL bp_ready c=%0d got=%b exp=0000", c, req_ready); end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_next_grant got=%b exp=0001", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_released got=%b exp=0", resp_valid); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_op;
    logic [3:0]  rdy;
    logic        rv;
    logic [1:0]  id;
    logic [31:0] res;
    do_reset;
    do_op(2, 32'd1, 32'd2, 3'b000, rdy, rv, id, res);
    total++; if (id !== 2'd2 || res !== 32'd1) begin bad++; $display("FAIL mid_setup got id=%0d res=%h exp id=2 res=1", id, res); end
    @(negedge clk);
    set_req(3, 32'd1, 32'd2, 3'b000);
    req_valid = 4'b1000;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_exec_busy got=%b exp=1", busy); end
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", resp_valid); end
    total++; if (resp_id !== 2'd0 || resp_result !== 32'd0) begin bad++; $display("FAIL mid_outputs got id=%0d res=%h exp 0/0", resp_id, resp_result); end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mid_no_resp c=%0d got=%b exp=0", c, resp_valid); end
    end
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr_grant got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    do_reset;
  endtask

  task automatic test_boundaries;
    logic [3:0]  rdy;
    logic        rv;
    logic [1:0]  id;
    logic [31:0] res;
    do_reset;
    do_op(2, 32'hFFFF_FFFF, 32'd0, 3'b011, rdy, rv, id, res);
    total++; if (rv !== 1'b1 || res !== 32'd1) begin bad++; $display("FAIL bound_gt got v=%b res=%h exp v=1 res=1", rv, res); end
    do_op(3, 32'd0, 32'hFFFF_FFFF, 3'b100, rdy, rv, id, res);
    total++; if (rv !== 1'b1 || res !== 32'd0) begin bad++; $display("FAIL bound_ge got v=%b res=%h exp v=1 res=0", rv, res); end
    total++; if (id !== 2'd3) begin bad++; $display("FAIL bound_id got=%0d exp=3", id); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    resp_ready = 1'b1;
    test_reset;
    test_single;
    test_ops;
    test_round_robin;
    test_backpressure;
    test_reset_mid_op;
    test_boundaries;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
